// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//   Multi-cycle add/subtract of two WIDTH-bit operands through one 4-bit slice.
//   One nibble is processed per RUN cycle, low nibble first, with the slice
//   carry chained across cycles. A full-width result and {z,n,v,c} condition
//   codes are published on the edge that enters DONE.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   operation request, accepted only in IDLE or DONE
//   sub     0: a+b, 1: a-b (captured with start)
//   a, b    WIDTH-bit operands (captured with start)
//   busy    high while the slice is stepping through nibbles
//   done    one-cycle pulse; result/cc valid from this cycle on
//   result  registered sum/difference, modulo 2^WIDTH
//   cc      {z,n,v,c}; for subtract c=1 means no borrow
module nibble_serial_addsub #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [WIDTH-1:0] work_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;

  // Slice datapath signals
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum5;
  logic             c3;
  logic             c4;
  logic             last;
  logic [WIDTH-1:0] work_d;

  // Select the current nibble with constant-index slices and merge the slice
  // sum back into the working register at the same position.
  always_comb begin
    a_nib  = 4'h0;
    b_nib  = 4'h0;
    work_d = work_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4] ^ {4{sub_q}};
      end
    end
    sum5 = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the bit-3 sum: s3 = a3 ^ b3 ^ cin3.
    c3   = a_nib[3] ^ b_nib[3] ^ sum5[3];
    c4   = sum5[4];
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        work_d[4*i +: 4] = sum5[3:0];
      end
    end
    last = (idx_q == IdxW'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cc      <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= sub;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q  <= work_d;
          carry_q <= c4;
          idx_q   <= idx_q + IdxW'(1);
          if (last) begin
            result  <= work_d;
            cc      <= {(work_d == '0), work_d[WIDTH-1], c4 ^ c3, c4};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   cc;

  int npass  = 0;
  int ntotal = 0;

  nibble_serial_addsub #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cc     (cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_r;
    logic [3:0]  exp_cc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                       output logic [15:0] r, output logic [3:0] c_out);
    int ua, ub, sa, sb, ures, sres;
    logic z, n, v, c;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures > 65535);
    end
    r = 16'(ures);
    v = (sres > 32767) || (sres < -32768);
    z = (r == 16'h0000);
    n = r[15];
    c_out = {z, n, v, c};
  endtask

  // Launch one operation, optionally scrambling inputs while it runs, and
  // check latency, busy length, result, cc and the single-cycle done pulse.
  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic ts, input logic [15:0] exp_r, input logic [3:0] exp_cc,
                        input bit scramble);
    int cyc;
    int bc;
    @(negedge clk);
    a = ta; b = tbv; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    bc  = 0;
    while (!done && cyc < 20) begin
      if (busy) bc++;
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, NIB);
    check({name, " busy_cycles"}, bc, NIB);
    check({name, " result"}, {16'h0, result}, {16'h0, exp_r});
    check({name, " cc"}, {28'h0, cc}, {28'h0, exp_cc});
    @(posedge clk); #1;
    check({name, " done_pulse"}, {31'h0, done}, 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] ra, rb, er;
    logic        rs;
    logic [3:0]  ec;
    int          cnt;
    int          ndone;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0110};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1001};
    vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0100};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1011};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset result", {16'h0, result}, 32'h0);
    check("reset cc", {28'h0, cc}, 32'h0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].exp_r, vecs[i].exp_cc, 1'b0);
    end

    // Random operations against the reference, inputs scrambled during RUN
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(3) == 0) ra = (i % 2 == 0) ? 16'hFFFF : 16'h8000;
      if ($urandom_range(3) == 0) rb = (i % 3 == 0) ? 16'h0001 : 16'h7FFF;
      model(ra, rb, rs, er, ec);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, er, ec, 1'b1);
    end

    // Back-to-back: start held high through RUN and into DONE
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0005;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b2b first result", {16'h0, result}, 32'h0);
    check("b2b first cc", {28'h0, cc}, 32'h9);
    cnt = 0;
    @(posedge clk); #1;
    cnt++;
    while (!done && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("b2b spacing", cnt, NIB + 1);
    check("b2b second result", {16'h0, result}, 32'hFFFE);
    check("b2b second cc", {28'h0, cc}, 32'h4);
    @(posedge clk); #1;
    check("b2b idle after", {31'h0, busy}, 32'h0);

    // start during RUN is ignored and not queued
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'hFFFF; b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ignore result", {16'h0, result}, 32'h2345);
    check("ignore cc", {28'h0, cc}, 32'h0);
    @(posedge clk); #1;
    check("ignore not queued", {31'h0, busy}, 32'h0);

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort result", {16'h0, result}, 32'h0);
    check("abort cc", {28'h0, cc}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    check("abort no done", ndone, 0);

    // rst and start together stay IDLE
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    check("rst+start busy", {31'h0, busy}, 32'h0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst+start stays idle", {31'h0, busy}, 32'h0);
    check("rst+start no done", {31'h0, done}, 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle add/subtract sequencer that processes a WIDTH-bit operation one 4-bit nibble per clock through a single internal 4-bit add/sub slice. Nibble carries are chained across cycles. The block produces a full-width result and a {z,n,v,c} condition-code nibble. It is the area-reduced datapath option for operands wider than one slice, sitting between the operand registers and the condition-code consumer.

## Interface
- NIBBLES, 4: number of 4-bit slices; WIDTH = 4*NIBBLES; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result/cc valid from this cycle on.
- result  output  WIDTH  registered sum/difference.
- cc  output  4  {z,n,v,c}: cc[3]=z, cc[2]=n, cc[1]=v, cc[0]=c.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1.
  - Latch a, b and sub.
  - Set the carry register to sub.
  - Set the nibble index to 0.
- RUN, each cycle at index i:
  - Slice computes a[4i+3:4i] + (b[4i+3:4i] ^ {4{sub}}) + carry.
  - The 4-bit sum is written into working-register nibble i.
  - carry <= slice carry-out.
  - When i = NIBBLES-1, also capture the slice carry into bit 3 (c3) and the carry-out (c4).
  - Index increments.
- RUN -> DONE after nibble NIBBLES-1 is processed. On that same edge:
  - result <= full working register.
  - z <= (full-width working value == 0), not per nibble.
  - n <= working MSB.
  - v <= c4 ^ c3.
  - c <= c4. For subtract, c=1 means no borrow.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 -> RUN, with the same latch actions as IDLE, giving back-to-back operation.
  - Otherwise -> IDLE.
- start in RUN is ignored and is not queued.
- result and cc hold their last values through IDLE and through the following RUN. They change only on the edge that enters DONE.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset: rst=1 at an edge forces IDLE regardless of state.
  - busy=0, done=0, result=0, cc=4'b0000.
  - Working register, carry and index are cleared.
  - An in-flight operation is aborted and produces no done.
- rst has priority over start on the same edge.
- Latency: start sampled at edge E.
  - busy=1 from E through E+NIBBLES.
  - done=1 and result/cc updated in the cycle following edge E+NIBBLES.
  - NIBBLES=4: 4 edges from accept to done.
- Throughput: with start held high, one operation per NIBBLES+1 cycles.
- Operands are captured at accept. Changes to a/b/sub during RUN have no effect.
- NIBBLES=1: a single RUN cycle, then DONE.

## Test plan
1. Add 0x1234 + 0x1111, start at edge 0 -> done after edge 4, result=0x2345, cc=4'b0000; busy high for exactly 4 cycles.
2. Add 0xFFFF + 0x0001 -> result=0x0000, cc=4'b1001 (z=1, c=1). This checks that the carry ripples across all four RUN cycles.
3. Add 0x7FFF + 0x0001 -> result=0x8000, cc=4'b0110 (n=1, v=1, c=0).
4. Subtract:
   - 0x0005 - 0x0005 -> 0x0000, cc=4'b1001.
   - Then, back-to-back with start held in DONE, 0x0003 - 0x0005 -> 0xFFFE, cc=4'b0100.
   - Second done appears exactly 5 cycles after the first.
5. Subtract 0x8000 - 0x0001 -> result=0x7FFF, cc=4'b0011 (v=1, c=1).
6. Busy and reset behaviour:
   - Pulse start with new operands during RUN -> ignored; the first operation's result is unchanged.
   - Assert rst at the 2nd RUN cycle -> next cycle busy=0, result=0, cc=0, no done pulse.
   - rst and start asserted together -> remains IDLE.
